// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch path and the 32-entry instruction memory.
package ifetch_pkg;
    localparam int IM_ADDR_W = 5;
    localparam int IM_DATA_W = 32;

    localparam logic [IM_ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [IM_ADDR_W-1:0] pc;
        logic [IM_DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head data is shown directly from storage
// and falls back to the last shown head while empty so the output never goes X.
module fetch_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             nonempty;
    logic             do_push, do_pop;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    // Pointers wrap naturally because DEPTH is a power of two.
    assign do_push  = push & ~flush & (~full | do_pop);
    assign do_pop   = pop & ~flush & nonempty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (nonempty) last_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = nonempty ? mem_q[rd_ptr_q] : last_q;
    assign count = count_q;
endmodule

// File: rtl/ifetch_unit.sv
// Fetch master: owns the fetch PC, drives the instruction memory address and
// streams {pc, instr} to decode through a prefetch FIFO; redirect flushes and restarts.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int ADDR_W = IM_ADDR_W,
    parameter int DATA_W = IM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            im_pc,
    input  logic [DATA_W-1:0]            im_instr,
    input  logic                         fetch_en,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_instr,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [EW-1:0]     head;
    logic              full;
    logic              pop, push;

    assign pop  = out_valid & out_ready;
    assign push = fetch_en & ~redirect_valid & (~full | pop);

    // Redirect outranks push; a pc increment only happens with an accepted push.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) pc_d = redirect_pc;
        else if (push)      pc_d = pc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= ADDR_W'(RESET_PC);
        else       pc_q <= pc_d;
    end

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({pc_q, im_instr}),
        .dout  (head),
        .count (occupancy),
        .full  (full)
    );

    assign im_pc     = pc_q;
    assign out_valid = (occupancy != '0);
    assign out_pc    = head[EW-1 -: ADDR_W];
    assign out_instr = head[DATA_W-1:0];
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a combinational 32-word memory model.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  im_pc;
    logic [31:0] im_instr;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [4:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [4:0]  out_pc;
    logic [2:0]  occupancy;

    logic [31:0] mem [32];
    int checks = 0;
    int failures = 0;
    fetch_entry_t exp_e;

    assign im_instr = mem[im_pc];

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .reset(reset), .im_pc(im_pc), .im_instr(im_instr),
        .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after an edge with reset just released and all inputs idle.
    task automatic apply_reset();
        tick();
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, occupancy, im_pc, out_pc, out_instr} !== {1'b0, 3'd0, 5'd0, 5'd0, 32'd0}) begin
            $display("FAIL reset_state got v=%b occ=%0d im_pc=%0d pc=%0d instr=%h exp all zero",
                     out_valid, occupancy, im_pc, out_pc, out_instr);
            failures++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL stream_pre_valid got %b exp 0", out_valid); failures++;
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_e.pc = 5'(k); exp_e.instr = mem[k];
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, exp_e}) begin
                $display("FAIL stream_%0d got v=%b pc=%0d instr=%h exp v=1 pc=%0d instr=%h",
                         k, out_valid, out_pc, out_instr, exp_e.pc, exp_e.instr);
                failures++;
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({occupancy, im_pc} !== {3'((k > 4) ? 4 : k), 5'((k > 4) ? 4 : k)}) begin
                $display("FAIL bp_fill_%0d got occ=%0d im_pc=%0d exp occ=%0d im_pc=%0d",
                         k, occupancy, im_pc, (k > 4) ? 4 : k, (k > 4) ? 4 : k);
                failures++;
            end
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, 5'd0, 32'h200}) begin
                $display("FAIL bp_head_%0d got v=%b pc=%0d instr=%h exp v=1 pc=0 instr=00000200",
                         k, out_valid, out_pc, out_instr);
                failures++;
            end
        end
        // Full with pop and push every cycle: occupancy holds, both pointers move.
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_e.pc = 5'(k); exp_e.instr = mem[k];
            checks++;
            if ({out_valid, out_pc, out_instr, occupancy, im_pc} !== {1'b1, exp_e, 3'd4, 5'(4 + k)}) begin
                $display("FAIL bp_drain_%0d got pc=%0d instr=%h occ=%0d im_pc=%0d exp pc=%0d instr=%h occ=4 im_pc=%0d",
                         k, out_pc, out_instr, occupancy, im_pc, exp_e.pc, exp_e.instr, 4 + k);
                failures++;
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (occupancy !== 3'd3) begin
            $display("FAIL redir_pre_occ got %0d exp 3", occupancy); failures++;
        end
        redirect_valid = 1'b1; redirect_pc = 5'd20; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if ({out_valid, occupancy, im_pc, out_pc, out_instr} !== {1'b0, 3'd0, 5'd20, 5'd0, 32'h200}) begin
            $display("FAIL redir_flush got v=%b occ=%0d im_pc=%0d pc=%0d instr=%h exp v=0 occ=0 im_pc=20 pc=0 instr=00000200",
                     out_valid, occupancy, im_pc, out_pc, out_instr);
            failures++;
        end
        tick();
        exp_e.pc = 5'd20; exp_e.instr = mem[20];
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, exp_e}) begin
            $display("FAIL redir_first got v=%b pc=%0d instr=%h exp v=1 pc=20 instr=%h",
                     out_valid, out_pc, out_instr, exp_e.instr);
            failures++;
        end
        // Back-to-back redirects while fetch is disabled: last wins, nothing pushed.
        fetch_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 5'd10;
        tick();
        redirect_pc = 5'd12;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, occupancy, im_pc} !== {1'b0, 3'd0, 5'd12}) begin
            $display("FAIL redir_b2b got v=%b occ=%0d im_pc=%0d exp v=0 occ=0 im_pc=12",
                     out_valid, occupancy, im_pc);
            failures++;
        end
        fetch_en = 1'b1;
        tick();
        exp_e.pc = 5'd12; exp_e.instr = mem[12];
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, exp_e}) begin
            $display("FAIL redir_b2b_first got v=%b pc=%0d instr=%h exp v=1 pc=12 instr=%h",
                     out_valid, out_pc, out_instr, exp_e.instr);
            failures++;
        end
    endtask

    task automatic test_wrap();
        logic [4:0] pcs [4];
        pcs[0] = 5'd30; pcs[1] = 5'd31; pcs[2] = 5'd0; pcs[3] = 5'd1;
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 5'd30;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_e.pc = pcs[k]; exp_e.instr = mem[pcs[k]];
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, exp_e}) begin
                $display("FAIL wrap_%0d got v=%b pc=%0d instr=%h exp v=1 pc=%0d instr=%h",
                         k, out_valid, out_pc, out_instr, exp_e.pc, exp_e.instr);
                failures++;
            end
        end
    endtask

    task automatic test_fetch_disable();
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick();
        fetch_en = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if ({occupancy, im_pc, out_pc} !== {3'd1, 5'd2, 5'd1}) begin
            $display("FAIL dis_drain got occ=%0d im_pc=%0d pc=%0d exp occ=1 im_pc=2 pc=1",
                     occupancy, im_pc, out_pc);
            failures++;
        end
        tick(); tick(); tick();
        checks++;
        if ({out_valid, occupancy, im_pc, out_pc, out_instr} !== {1'b0, 3'd0, 5'd2, 5'd1, 32'h201}) begin
            $display("FAIL dis_empty got v=%b occ=%0d im_pc=%0d pc=%0d instr=%h exp v=0 occ=0 im_pc=2 pc=1 instr=00000201",
                     out_valid, occupancy, im_pc, out_pc, out_instr);
            failures++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fetch_en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (occupancy !== 3'd3) begin
            $display("FAIL arst_pre_occ got %0d exp 3", occupancy); failures++;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, occupancy, im_pc} !== {1'b0, 3'd0, 5'd0}) begin
            $display("FAIL arst_immediate got v=%b occ=%0d im_pc=%0d exp v=0 occ=0 im_pc=0",
                     out_valid, occupancy, im_pc);
            failures++;
        end
        tick();
        reset = 1'b0; out_ready = 1'b1;
        tick();
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 5'd0, 32'h200}) begin
            $display("FAIL arst_restart got v=%b pc=%0d instr=%h exp v=1 pc=0 instr=00000200",
                     out_valid, out_pc, out_instr);
            failures++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + 32'(i);
        mem[0] = 32'h200; mem[1] = 32'h201; mem[2] = 32'h204; mem[3] = 32'h108;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_fetch_disable();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side master for the 32-entry instruction memory: owns the fetch PC and drives the memory's 5-bit word address.
- Captures the returned 32-bit word into a small prefetch FIFO and presents {pc, instr} to the decode stage over a valid/ready handshake.
- Supports a branch/jump redirect that flushes the FIFO and restarts fetch at a new address.

Parameters:
- ADDR_W, 5, word-address width; memory holds 2**ADDR_W words.
- DATA_W, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- im_pc  out  ADDR_W  word address to instruction memory; equals the internal fetch_pc.
- im_instr  in  DATA_W  memory read data; combinational from im_pc, sampled at the clk edge.
- fetch_en  in  1  enables fetching; 0 freezes fetch_pc and pushes, while pops continue.
- redirect_valid  in  1  one-cycle request to restart fetch.
- redirect_pc  in  ADDR_W  new fetch address; sampled when redirect_valid=1.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  address the head instruction was fetched from.
- occupancy  out  $clog2(DEPTH+1)  current FIFO entry count.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: fetch_pc=0, so im_pc=0. FIFO is empty, with wr_ptr=rd_ptr=0 and count=0. out_valid=0, out_instr=0, out_pc=0, occupancy=0. FIFO storage does not require reset.
- Asserting reset mid-operation discards all FIFO contents immediately (asynchronously). Fetch resumes from address 0 on the first edge after release.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop).
- Push is allowed when the FIFO is full only if a pop occurs in the same cycle.
- On push: write {fetch_pc, im_instr} at wr_ptr, then set fetch_pc <= fetch_pc+1 modulo 2**ADDR_W, so 31 wraps to 0.
- On pop: advance rd_ptr.
- Count update: +1 on push only, -1 on pop only, unchanged when both occur.
- out_valid = (count != 0). out_instr and out_pc are driven directly from the entry at rd_ptr and must be stable while out_valid=1 and out_ready=0.
- Fetch latency: the first edge with push=1 after reset makes out_valid=1 in the following cycle, i.e. one-cycle memory-to-decode latency.
- Redirect (highest priority after reset):
  - At the edge where redirect_valid=1: fetch_pc <= redirect_pc; count, wr_ptr and rd_ptr are set to 0; no push occurs.
  - A simultaneous pop completes the handshake from decode's view, but has no further effect on state.
  - Next cycle: out_valid=0 and im_pc=redirect_pc.
  - The first redirected instruction appears with out_valid=1 two cycles after the redirect edge, provided fetch_en=1.
- Back-to-back redirects: the last one wins, and each one flushes.
- fetch_en=0: no pushes and fetch_pc holds; the FIFO drains normally. A redirect while fetch_en=0 still updates fetch_pc and flushes.
- Empty with out_ready=1: no pop occurs and count does not underflow.
- Full with pop=0: no push occurs, fetch_pc holds, and im_pc stays stable.
- Steady state with out_ready tied high sustains one instruction per cycle.
- No X propagation: out_instr and out_pc hold their last head values when the FIFO is empty. Read data is don't-care while out_valid=0.

Decomposition:
- Shared package ifetch_pkg holds:
  - constants IM_ADDR_W=5 and IM_DATA_W=32, also used by the memory;
  - a packed struct fetch_entry_t {pc, instr};
  - the reset value for fetch_pc, RESET_PC=0.
- One sub-module, fetch_fifo: a parameterized synchronous FIFO with a flush input, push/pop, head data out, and count.
- ifetch_unit keeps the PC register, the push/redirect control, and the memory interface.

Test Plan:
- Reset release with memory words 0x200,0x201,0x204,0x108 at addresses 0-3, fetch_en=1, out_ready=1 -> out_valid rises one cycle after the first edge. The bench sees (pc,instr) = (0,0x200), (1,0x201), (2,0x204), (3,0x108) on consecutive cycles.
- out_ready=0 from reset, fetch_en=1 -> occupancy counts to 4 and saturates. im_pc holds at 4. The head stays (0,0x200) and is stable. Raising out_ready then drains in order with no gaps or duplicates.
- Redirect with redirect_pc=20 while the FIFO holds 3 entries -> next cycle out_valid=0, occupancy=0 and im_pc=20. The first delivered entry is (20,mem[20]), two cycles after the redirect.
- Fetch at address 30 with out_ready=1 -> delivered pcs are 30, 31, 0, 1: wrap-around with no stall.
- Full FIFO with pop and push in the same cycle -> occupancy stays 4 and both pointers advance. A push on a full FIFO without a pop is suppressed.
- Assert reset asynchronously mid-stream with occupancy=3 -> out_valid and occupancy drop to 0 before the next clk edge. After release, fetch restarts at pc 0.
